// File: rtl/mwa_key_entry.sv
// Keypad entry controller for the oven: collects a 0..15 cook time, launches the oven, and tracks its run.
// Optional quick-start (START from IDLE launches a 1-unit cook) is enabled by defining MWA_KEY_QUICKSTART_EN.
module mwa_key_entry (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       busy,
    output logic [3:0] tin,
    output logic       r,
    output logic [3:0] entry,
    output logic       err
);

    localparam int unsigned KEY_W   = 4;
    localparam int unsigned CALC_W  = 8;
    localparam logic [KEY_W-1:0] KEY_START = 4'hA;
    localparam logic [KEY_W-1:0] KEY_CLEAR = 4'hB;
    localparam logic [KEY_W-1:0] ENTRY_MAX = 4'd15;
    localparam logic [1:0]       WAIT_LAST = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        LAUNCH  = 2'd2,
        RUNNING = 2'd3
    } state_t;

    state_t             r_state;
    logic [KEY_W-1:0]   r_entry;
    logic [KEY_W-1:0]   r_tin;
    logic               r_start;
    logic               r_err;
    logic               r_seen_busy;
    logic [1:0]         r_wait;

    logic               w_is_digit;
    logic               w_is_invalid;
    logic [CALC_W-1:0]  w_next_entry;

    assign w_is_digit   = (key_code <= 4'd9);
    assign w_is_invalid = (key_code >= 4'hC);
    // Decimal shift-in at 8 bits so overflow past 15 is detectable.
    assign w_next_entry = CALC_W'(r_entry) * CALC_W'(10) + CALC_W'(key_code);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_entry     <= '0;
            r_tin       <= '0;
            r_start     <= 1'b0;
            r_err       <= 1'b0;
            r_seen_busy <= 1'b0;
            r_wait      <= '0;
        end else begin
            r_start <= 1'b0;
            r_tin   <= '0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (key_valid) begin
                        if (w_is_invalid) begin
                            r_err <= 1'b1;
                        end else if (w_is_digit) begin
                            r_state <= ENTRY;
                            r_entry <= key_code;
                        end else if (key_code == KEY_START) begin
`ifdef MWA_KEY_QUICKSTART_EN
                            if (!busy) begin
                                r_state <= LAUNCH;
                                r_start <= 1'b1;
                                r_tin   <= 4'd1;
                            end else begin
                                r_err <= 1'b1;
                            end
`else
                            r_err <= 1'b1;
`endif
                        end
                    end
                end
                ENTRY: begin
                    if (key_valid) begin
                        if (w_is_invalid) begin
                            r_err <= 1'b1;
                        end else if (w_is_digit) begin
                            if (w_next_entry > CALC_W'(ENTRY_MAX)) begin
                                r_entry <= ENTRY_MAX;
                                r_err   <= 1'b1;
                            end else begin
                                r_entry <= w_next_entry[KEY_W-1:0];
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            r_state <= IDLE;
                            r_entry <= '0;
                        end else if (busy) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= LAUNCH;
                            r_start <= 1'b1;
                            r_tin   <= r_entry;
                        end
                    end
                end
                LAUNCH: begin
                    r_err       <= key_valid;
                    r_state     <= RUNNING;
                    r_seen_busy <= 1'b0;
                    r_wait      <= '0;
                end
                RUNNING: begin
                    r_err <= key_valid;
                    if (busy) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_state <= IDLE;
                        r_entry <= '0;
                    end else if (r_wait == WAIT_LAST) begin
                        // Oven never acknowledged the start pulse.
                        r_state <= IDLE;
                        r_entry <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tin   = r_tin;
    assign r     = r_start;
    assign entry = r_entry;
    assign err   = r_err;

endmodule

// File: tb/tb_mwa_key_entry.sv
// Self-checking bench for mwa_key_entry: directed scenarios plus randomized key/busy traffic
// compared every cycle against a behavioural model of the keypad rules.
module tb_mwa_key_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       busy = 1'b0;
    logic [3:0] tin;
    logic       r;
    logic [3:0] entry;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: which phase the cooker UI is in, the typed value, and run bookkeeping.
    int m_phase   = 0;   // 0 waiting, 1 typing, 2 launching, 3 cooking
    int m_value   = 0;
    int m_seen    = 0;
    int m_idle_n  = 0;
    int exp_tin   = 0;
    int exp_r     = 0;
    int exp_err   = 0;

    mwa_key_entry dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .busy      (busy),
        .tin       (tin),
        .r         (r),
        .entry     (entry),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock given the inputs seen at that edge.
    task automatic model_edge(input int v, input int code, input int b, input int rs);
        exp_tin = 0; exp_r = 0; exp_err = 0;
        if (rs != 0) begin
            m_phase = 0; m_value = 0;
            return;
        end
        if (m_phase >= 2) begin
            if (v != 0) exp_err = 1;
            if (m_phase == 2) begin
                m_phase = 3; m_seen = 0; m_idle_n = 0;
            end else if (b != 0) begin
                m_seen = 1;
            end else if (m_seen != 0) begin
                m_phase = 0; m_value = 0;
            end else begin
                m_idle_n++;
                if (m_idle_n >= 4) begin
                    m_phase = 0; m_value = 0; exp_err = 1;
                end
            end
            return;
        end
        if (v == 0) return;
        if (code >= 12) begin
            exp_err = 1;
        end else if (code <= 9) begin
            if (m_phase == 0) begin
                m_phase = 1; m_value = code;
            end else if (m_value * 10 + code > 15) begin
                m_value = 15; exp_err = 1;
            end else begin
                m_value = m_value * 10 + code;
            end
        end else if (code == 11) begin
            m_phase = 0; m_value = 0;
        end else if (m_phase == 1) begin
            if (b != 0) exp_err = 1;
            else begin
                m_phase = 2; exp_r = 1; exp_tin = m_value;
            end
        end else begin
`ifdef MWA_KEY_QUICKSTART_EN
            if (b != 0) exp_err = 1;
            else begin
                m_phase = 2; exp_r = 1; exp_tin = 1;
            end
`else
            exp_err = 1;
`endif
        end
    endtask

    task automatic step(input int v, input int code, input int b, input int rs);
        key_valid = 1'(v);
        key_code  = 4'(code);
        busy      = 1'(b);
        rst       = 1'(rs);
        model_edge(v, code, b, rs);
        @(posedge clk);
        #1;
        chk("tin",   int'(tin),   exp_tin);
        chk("r",     int'(r),     exp_r);
        chk("entry", int'(entry), m_value);
        chk("err",   int'(err),   exp_err);
    endtask

    task automatic key(input int code, input int b);
        step(1, code, b, 0);
    endtask

    task automatic idle_cyc(input int b);
        step(0, 0, b, 0);
    endtask

    initial begin
        int b_rand;
        int code;

        // Reset state.
        step(0, 0, 0, 1);
        chk("rst_entry", int'(entry), 0);
        chk("rst_r", int'(r), 0);
        idle_cyc(0);

        // 4, START -> one-cycle launch with tin=4, then run with busy high 5 cycles.
        key(4, 0);
        key(10, 0);
        chk("launch4_r", int'(r), 1);
        chk("launch4_tin", int'(tin), 4);
        idle_cyc(0);
        chk("launch4_r_drop", int'(r), 0);
        chk("launch4_tin_drop", int'(tin), 0);
        idle_cyc(1);
        key(7, 1);
        chk("run_key_err", int'(err), 1);
        chk("run_key_entry", int'(entry), 4);
        for (int i = 0; i < 3; i++) idle_cyc(1);
        idle_cyc(0);
        chk("busy_fall_entry", int'(entry), 0);
        key(12, 0);
        chk("invalid_idle_err", int'(err), 1);

        // 1, 2, START -> tin 12, then timeout with busy never rising.
        key(1, 0);
        key(2, 0);
        key(10, 0);
        chk("launch12_tin", int'(tin), 12);
        idle_cyc(0);
        for (int i = 0; i < 3; i++) begin
            idle_cyc(0);
            chk("timeout_wait_err", int'(err), 0);
        end
        idle_cyc(0);
        chk("timeout_err", int'(err), 1);
        chk("timeout_entry", int'(entry), 0);

        // 9, 9 saturates at 15 with a single error pulse.
        key(9, 0);
        chk("nine_err", int'(err), 0);
        key(9, 0);
        chk("sat_entry", int'(entry), 15);
        chk("sat_err", int'(err), 1);
        idle_cyc(0);
        chk("sat_err_single", int'(err), 0);
        key(10, 1);
        chk("start_busy_err", int'(err), 1);
        key(11, 0);

        // 7, CLEAR, START -> no launch.
        key(7, 0);
        key(11, 0);
        chk("clear_entry", int'(entry), 0);
        key(10, 0);
`ifndef MWA_KEY_QUICKSTART_EN
        chk("idle_start_r", int'(r), 0);
        chk("idle_start_err", int'(err), 1);
`else
        chk("quick_r", int'(r), 1);
        chk("quick_tin", int'(tin), 1);
        step(0, 0, 0, 1);
`endif

        // Reset during the launch cycle aborts the pulse.
        key(3, 0);
        key(10, 0);
        chk("pre_rst_r", int'(r), 1);
        step(0, 0, 0, 1);
        chk("rst_launch_r", int'(r), 0);
        chk("rst_launch_entry", int'(entry), 0);
        idle_cyc(0);

        // Randomized traffic.
        b_rand = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) b_rand = 1 - b_rand;
            if ($urandom_range(0, 199) == 0) begin
                step(0, 0, b_rand, 1);
            end else if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: code = 10;
                    3:       code = 11;
                    4:       code = int'($urandom_range(12, 15));
                    default: code = int'($urandom_range(0, 9));
                endcase
                step(1, code, b_rand, 0);
            end else begin
                step(0, int'($urandom_range(0, 15)), b_rand, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mwa_key_entry.md
MWA_KEY_ENTRY -- requirements
Module: mwa_key_entry

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high; the ports SHALL be named clk and rst.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 key_valid  input  1  a key event is present this cycle.
REQ-005 key_code  input  4  key code: 0-9 digit, 0xA START, 0xB CLEAR; codes 0xC-0xF are invalid.
REQ-006 busy  input  1  the oven is running; this is the downstream power output p.
REQ-007 tin  output  4  cook time handed to the oven; valid only while r=1, 0 otherwise.
REQ-008 r  output  1  one-cycle start pulse to the oven.
REQ-009 entry  output  4  current entered value, for the display.
REQ-010 err  output  1  one-cycle error pulse.

Function
REQ-011 All outputs SHALL be registered.
REQ-012 FSM states SHALL be IDLE, ENTRY, LAUNCH and RUNNING.
REQ-013 IDLE: entry=0.
- A digit d SHALL move the block to ENTRY with entry=d.
- START SHALL be handled as in REQ-024/025.
- CLEAR SHALL leave the block in IDLE with no error.
REQ-014 ENTRY, digit d: next = entry*10+d, computed at 8 bits; if next>15 then entry=15 and err pulses.
REQ-015 ENTRY, CLEAR: the block SHALL go to IDLE with entry=0.
REQ-016 ENTRY, START: if busy=0, the block SHALL go to LAUNCH; if busy=1, it SHALL pulse err and stay in ENTRY.
REQ-017 LAUNCH lasts exactly one cycle: r=1 and tin=entry in the cycle after START is sampled. The next state is RUNNING.
REQ-018 RUNNING:
- Track a seen_busy flag.
- When busy falls after seen_busy=1, the block SHALL go to IDLE with entry=0.
- If busy never rises within 4 cycles of entering RUNNING, the block SHALL go to IDLE and pulse err.
REQ-019 Any key in LAUNCH or RUNNING SHALL be ignored and SHALL pulse err.
REQ-020 An invalid key code (0xC-0xF) in any state SHALL pulse err with no state change.
REQ-021 If key_valid=0, no transition SHALL occur other than the RUNNING exits.
REQ-022 err SHALL be high for exactly one cycle per offending event.

Reset
REQ-023 rst=1 at any clock edge SHALL force state=IDLE, entry=0, tin=0, r=0 and err=0 at that edge. This applies even mid-LAUNCH or mid-RUNNING, and any pulse in flight SHALL be aborted.

Configuration
REQ-024 With macro MWA_KEY_QUICKSTART_EN defined: START in IDLE with busy=0 SHALL go to LAUNCH with tin=1.
REQ-025 Without MWA_KEY_QUICKSTART_EN: START in IDLE SHALL pulse err and stay in IDLE.

Verification
REQ-026 Keys 4, START with busy=0 -> r=1 and tin=4 for exactly one cycle, one cycle after START; then RUNNING.
REQ-027 Keys 1, 2, START -> tin=12. Keys 9, 9 -> entry=15 and err pulses once on the second 9.
REQ-028 Keys 7, CLEAR, START without the macro -> entry=0, no r pulse, err pulses on START.
REQ-029 After launch, drive busy high for 5 cycles then low -> IDLE one cycle after the fall. A digit key while busy=1 -> err, entry unchanged.
REQ-030 After launch, hold busy=0 -> err pulses and the block is in IDLE 4 cycles after entering RUNNING.
REQ-031 Assert rst in the LAUNCH cycle -> r=0 at that edge, IDLE, entry=0. With MWA_KEY_QUICKSTART_EN, START from IDLE -> r=1, tin=1.
